rv_hazard_ctrl: RTL
===================

// Module: rv_hazard_ctrl
// PURPOSE
//  Pipeline hazard and stall controller for the 5-stage RV32IM core, sitting beside the IF/ID, ID/EX and EX/MEM registers.
//  Detects load-use hazards (x0-aware, per-operand use qualified) and flushes on a taken branch/jump resolved in MEM.
//  Adds multi-cycle MUL/DIV stalls via an EX-occupancy FSM, and saturating perf counters for stall/flush cycles.
// PARAMETERS
//  REG_AW   5   register-address width
//  MUL_LAT  2   total EX cycles for MUL/MULH*; legal range 1..255
//  DIV_LAT  34  total EX cycles for DIV/REM*; legal range 1..255
//  CNT_W    32  perf-counter width
// PORTS
//  clk           in   1       core clock
//  rst           in   1       synchronous reset, active-high
//  id_rs1        in   REG_AW  rs1 of instruction in ID
//  id_rs2        in   REG_AW  rs2 of instruction in ID
//  id_use_rs1    in   1       ID instruction reads rs1
//  id_use_rs2    in   1       ID instruction reads rs2
//  ex_rd         in   REG_AW  rd of instruction in EX
//  ex_mem_read   in   1       EX instruction is a load
//  ex_md_start   in   1       valid M-extension op in EX
//  ex_md_is_div  in   1       that op is DIV/DIVU/REM/REMU
//  mem_br_taken  in   1       branch/jump in MEM resolved taken
//  cnt_clr       in   1       synchronous clear of perf counters
//  pc_write      out  1       PC update enable
//  if_id_write   out  1       IF/ID load enable
//  id_ex_write   out  1       ID/EX load enable
//  id_ex_bubble  out  1       load NOP into ID/EX
//  ex_mem_bubble out  1       load NOP into EX/MEM
//  flush_if_id   out  1       kill IF/ID contents
//  flush_id_ex   out  1       kill ID/EX contents
//  flush_ex_mem  out  1       kill EX-stage instruction before EX/MEM
//  md_busy       out  1       FSM in MD_BUSY (registered)
//  cnt_load_use  out  CNT_W   load-use stall cycles
//  cnt_md_stall  out  CNT_W   MUL/DIV stall cycles
//  cnt_flush     out  CNT_W   branch-flush events
// BEHAVIOUR
//  - Defaults: pc_write=if_id_write=id_ex_write=1; all bubble/flush outputs 0.
//  - During rst: outputs at defaults; state=IDLE; md_cnt=0; md_busy=0; all counters 0.
//  - lat = ex_md_is_div ? DIV_LAT : MUL_LAT.
//  - FSM states IDLE, MD_BUSY; md_cnt is 8 bits.
//    IDLE & ex_md_start & lat>1 -> MD_BUSY, md_cnt<=lat-2.
//    IDLE & ex_md_start & lat==1 -> stay IDLE, no stall.
//    MD_BUSY & md_cnt!=0 -> md_cnt--.
//    MD_BUSY & md_cnt==0 -> IDLE (release cycle, no stall).
//    ex_md_start is ignored in MD_BUSY; it is the same held instruction.
//  - md_stall = (IDLE & ex_md_start & lat>1) | (MD_BUSY & md_cnt!=0).
//    This gives exactly lat-1 stall cycles and lat EX cycles.
//  - load_use = ex_mem_read & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
//  - Priority: flush > md_stall > load_use. Lower-priority terms are suppressed in the same cycle.
//  - flush (mem_br_taken): flush_if_id=flush_id_ex=flush_ex_mem=1; pc_write=1; FSM forced to IDLE, md_cnt<=0.
//    The wrong-path MUL/DIV is aborted mid-operation.
//  - md_stall: pc_write=if_id_write=id_ex_write=0; ex_mem_bubble=1.
//  - load_use: pc_write=if_id_write=0; id_ex_bubble=1; ID/EX still loads (the bubble).
//  - All control outputs are combinational from inputs and state, giving zero-cycle detection latency.
//  - Counters update next cycle and saturate at all-ones.
//    cnt_clr has priority over increment; rst overrides cnt_clr.
//    cnt_load_use and cnt_md_stall count one per stall cycle; cnt_flush counts one per flush cycle.
// STRUCTURE
//  - rv_pipe_pkg: md_state_t enum {IDLE, MD_BUSY}, REG_X0 constant, default MUL/DIV latency constants.
//  - Sub-module rv_sat_counter (#(W), clk, rst, clr, inc, q), instantiated 3x.
//  - FSM, md_cnt and priority mux live in this module.
// TESTING
//  1. ex_mem_read=1, ex_rd=5, id_rs2=5, id_use_rs2=1 -> pc_write=0, if_id_write=0, id_ex_bubble=1 for 1 cycle; cnt_load_use=1.
//  2. Same as 1 with ex_rd=0, or id_use_rs2=0 -> no stall; outputs at defaults.
//  3. MUL with MUL_LAT=2 -> 1 stall cycle with ex_mem_bubble=1; DIV with DIV_LAT=34 -> 33 stall cycles, md_busy high for 33 cycles.
//     Release cycle has pc_write=1; cnt_md_stall=34 total.
//  4. DIV start, then mem_br_taken on its 10th stall cycle -> that cycle all three flushes=1, pc_write=1; next cycle md_busy=0; cnt_flush=1.
//  5. rst asserted mid-DIV -> next cycle IDLE, md_busy=0, counters 0, outputs at defaults.
//  6. cnt_* preloaded to all-ones via force, then further stalls -> value holds; cnt_clr=1 -> 0 next cycle.

Source files
------------

// File: rtl/rv_pipe_pkg.sv
// Shared types and constants for the RV32IM pipeline control blocks.
// Holds the MUL/DIV occupancy state encoding and default latencies.
package rv_pipe_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  localparam int REG_X0      = 0;
  localparam int MUL_LAT_DEF = 2;
  localparam int DIV_LAT_DEF = 34;

endpackage

// File: rtl/rv_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Reset overrides clear, clear overrides increment.
module rv_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] ONE = W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + ONE;
    end
  end

endmodule

// File: rtl/rv_hazard_ctrl.sv
// Load-use / MUL-DIV stall and branch-flush controller for the 5-stage core.
// Control outputs are combinational; EX occupancy and perf counters are registered.
module rv_hazard_ctrl
  import rv_pipe_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_read,
  input  logic              ex_md_start,
  input  logic              ex_md_is_div,
  input  logic              mem_br_taken,
  input  logic              cnt_clr,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              id_ex_write,
  output logic              id_ex_bubble,
  output logic              ex_mem_bubble,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic              flush_ex_mem,
  output logic              md_busy,
  output logic [CNT_W-1:0]  cnt_load_use,
  output logic [CNT_W-1:0]  cnt_md_stall,
  output logic [CNT_W-1:0]  cnt_flush
);

  localparam logic [7:0] MUL_L = 8'(MUL_LAT);
  localparam logic [7:0] DIV_L = 8'(DIV_LAT);
  localparam logic [REG_AW-1:0] X0 = REG_AW'(REG_X0);

  md_state_t  state;
  logic [7:0] md_cnt;
  logic [7:0] lat;
  logic       md_go;
  logic       flush;
  logic       md_stall;
  logic       load_use;
  logic       rs_hit;

  assign lat   = ex_md_is_div ? DIV_L : MUL_L;
  assign md_go = (state == IDLE) && ex_md_start && (lat > 8'd1);

  assign rs_hit = (id_use_rs1 && (id_rs1 == ex_rd)) ||
                  (id_use_rs2 && (id_rs2 == ex_rd));

  // Priority chain: flush, then MUL/DIV stall, then load-use.
  assign flush    = !rst && mem_br_taken;
  assign md_stall = !rst && !flush &&
                    (md_go || ((state == MD_BUSY) && (md_cnt != 8'd0)));
  assign load_use = !rst && !flush && !md_stall &&
                    ex_mem_read && (ex_rd != X0) && rs_hit;

  assign pc_write      = !(md_stall || load_use);
  assign if_id_write   = !(md_stall || load_use);
  assign id_ex_write   = !md_stall;
  assign id_ex_bubble  = load_use;
  assign ex_mem_bubble = md_stall;
  assign flush_if_id   = flush;
  assign flush_id_ex   = flush;
  assign flush_ex_mem  = flush;
  assign md_busy       = (state == MD_BUSY);

  // A taken branch kills the wrong-path MUL/DIV held in EX.
  always_ff @(posedge clk) begin
    if (rst || mem_br_taken) begin
      state  <= IDLE;
      md_cnt <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (md_go) begin
            state  <= MD_BUSY;
            md_cnt <= lat - 8'd2;
          end
        end
        MD_BUSY: begin
          if (md_cnt != 8'd0) begin
            md_cnt <= md_cnt - 8'd1;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state  <= IDLE;
          md_cnt <= 8'd0;
        end
      endcase
    end
  end

  rv_sat_counter #(.W(CNT_W)) u_cnt_lu (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (load_use),
    .q   (cnt_load_use)
  );

  rv_sat_counter #(.W(CNT_W)) u_cnt_md (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (md_stall),
    .q   (cnt_md_stall)
  );

  rv_sat_counter #(.W(CNT_W)) u_cnt_fl (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (flush),
    .q   (cnt_flush)
  );

endmodule
